// File: rtl/vga_sched_pkg.sv
// Shared types and default sizing for the VGA draw scheduler.
// Defaults cover twelve clients and a full 160x120 clear before timing out.
package vga_sched_pkg;

    localparam int DEF_NUM_CLIENTS = 12;
    localparam int DEF_SEL_W       = 4;
    localparam int DEF_TIMEOUT     = 20000;
    localparam int DEF_TMR_W       = 15;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        GAP
    } sched_state_e;

endpackage

// File: rtl/vga_draw_scheduler_rr_pick.sv
// Combinational round-robin picker: the first requester above the last
// granted index, wrapping around, wins.
module rr_pick
    import vga_sched_pkg::*;
#(
    parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
    parameter int SEL_W       = DEF_SEL_W
) (
    input  logic [NUM_CLIENTS-1:0] req_i,
    input  logic [SEL_W-1:0]       last_i,
    output logic [SEL_W-1:0]       winner_o,
    output logic                   valid_o
);

    int idx;

    // Scan from the farthest candidate down to the nearest so the closest
    // requester after last_i overwrites any earlier hit.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        for (int k = NUM_CLIENTS; k >= 1; k--) begin
            idx = (int'(last_i) + k) % NUM_CLIENTS;
            if (req_i[SEL_W'(idx)]) begin
                winner_o = SEL_W'(idx);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_draw_scheduler.sv
// Shares the single VGA adapter write port among drawing clients: one grant
// at a time, start pulse, wait for done or timeout, one dead cycle, repeat.
module vga_draw_scheduler
    import vga_sched_pkg::*;
#(
    parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
    parameter int SEL_W       = DEF_SEL_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int TMR_W       = DEF_TMR_W
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [NUM_CLIENTS-1:0] done,
    output logic [NUM_CLIENTS-1:0] start,
    output logic [SEL_W-1:0]       select,
    output logic                   write_gate,
    output logic                   busy,
    output logic                   timeout_err
);

    sched_state_e     state_q, state_d;
    logic [SEL_W-1:0] select_q, select_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             tmo_q, tmo_d;

    logic [SEL_W-1:0] pick_winner;
    logic             pick_valid;

    rr_pick #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .SEL_W       (SEL_W)
    ) u_pick (
        .req_i    (req),
        .last_i   (last_q),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            select_q <= '0;
            last_q   <= SEL_W'(NUM_CLIENTS - 1);
            timer_q  <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            last_q   <= last_d;
            timer_q  <= timer_d;
            tmo_q    <= tmo_d;
        end
    end

    // select only moves on IDLE->START; done is looked at only in WAIT and
    // only for the granted client, and wins over a same-cycle timeout.
    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        last_d   = last_q;
        timer_d  = timer_q;
        tmo_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && pick_valid) begin
                    select_d = pick_winner;
                    state_d  = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                if (done[select_q]) begin
                    state_d = GAP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                last_d  = select_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start = '0;
        if (state_q == START) begin
            start[select_q] = 1'b1;
        end
    end

    assign select      = select_q;
    assign write_gate  = (state_q == START) || (state_q == WAIT);
    assign busy        = (state_q != IDLE);
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Directed checks of the VGA draw scheduler with a short timeout so the
// timeout path is reachable in a handful of cycles.
module tb_vga_draw_scheduler;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        enable = 1'b1;
    logic [11:0] req = '0;
    logic [11:0] done = '0;
    logic [11:0] start;
    logic [3:0]  select;
    logic        write_gate;
    logic        busy;
    logic        timeout_err;

    int assertions = 0;
    int failures   = 0;

    vga_draw_scheduler #(
        .NUM_CLIENTS (12),
        .SEL_W       (4),
        .TIMEOUT     (16),
        .TMR_W       (15)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .enable      (enable),
        .req         (req),
        .done        (done),
        .start       (start),
        .select      (select),
        .write_gate  (write_gate),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    // Outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        enable = 1'b1;
        req    = '0;
        done   = '0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Bounded wait for the next start pulse; n is the number of edges taken.
    task automatic wait_start(output logic [11:0] s, output bit ok, output int n);
        s  = '0;
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n++;
            if (start !== 12'h000) begin
                s  = start;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [11:0] s;
        bit ok;
        int n;
        $display("[TB] test_reset");
        resetn = 1'b0;
        req    = '0;
        done   = '0;
        enable = 1'b1;
        tick();
        assertions++;
        if (start !== 12'h000) begin failures++; $display("[TB] FAIL reset_start: got %h expected 000", start); end
        assertions++;
        if (select !== 4'd0) begin failures++; $display("[TB] FAIL reset_select: got %0d expected 0", select); end
        assertions++;
        if (write_gate !== 1'b0) begin failures++; $display("[TB] FAIL reset_write_gate: got %b expected 0", write_gate); end
        assertions++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        assertions++;
        if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end

        resetn = 1'b1;
        req    = 12'h020;
        tick();
        assertions++;
        if (start !== 12'h020) begin failures++; $display("[TB] FAIL first_grant_start: got %h expected 020", start); end
        assertions++;
        if (select !== 4'd5) begin failures++; $display("[TB] FAIL first_grant_select: got %0d expected 5", select); end
        tick();
        tick();
        tick();
        assertions++;
        if (write_gate !== 1'b1) begin failures++; $display("[TB] FAIL mid_wait_gate: got %b expected 1", write_gate); end

        #2;
        resetn = 1'b0;
        #1;
        assertions++;
        if ({select, write_gate, busy, start} !== 19'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: got sel=%0d gate=%b busy=%b start=%h expected all 0", select, write_gate, busy, start);
        end
        tick();
        resetn = 1'b1;
        wait_start(s, ok, n);
        assertions++;
        if (!ok || s !== 12'h020 || n != 1) begin
            failures++;
            $display("[TB] FAIL regrant_after_reset: got start=%h after %0d edges expected 020 after 1", s, n);
        end
        req = '0;
    endtask

    task automatic test_single();
        int ngate;
        int nstart;
        $display("[TB] test_single");
        do_reset();
        req = 12'h001;
        tick();
        assertions++;
        if (start !== 12'h001) begin failures++; $display("[TB] FAIL single_start: got %h expected 001", start); end
        ngate  = write_gate ? 1 : 0;
        nstart = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (write_gate === 1'b1) ngate++;
            if (start !== 12'h000) nstart++;
        end
        done = 12'h001;
        tick();
        if (write_gate === 1'b1) ngate++;
        done = '0;
        assertions++;
        if (ngate != 11) begin failures++; $display("[TB] FAIL single_gate_cycles: got %0d expected 11", ngate); end
        assertions++;
        if (nstart != 0) begin failures++; $display("[TB] FAIL single_start_width: got %0d extra start cycles expected 0", nstart); end
        tick();
        assertions++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_idle_busy: got %b expected 0", busy); end
        tick();
        assertions++;
        if (start !== 12'h001) begin failures++; $display("[TB] FAIL single_restart: got %h expected 001", start); end
        req = '0;
    endtask

    task automatic test_fairness();
        logic [11:0] s;
        logic [11:0] exp;
        bit ok;
        int n;
        $display("[TB] test_fairness");
        do_reset();
        req  = 12'hFFF;
        done = 12'hFFF;
        for (int g = 0; g < 13; g++) begin
            exp = 12'h001 << (g % 12);
            wait_start(s, ok, n);
            assertions++;
            if (!ok || s !== exp || select !== 4'(g % 12)) begin
                failures++;
                $display("[TB] FAIL fair_order_%0d: got start=%h sel=%0d expected start=%h sel=%0d", g, s, select, exp, g % 12);
            end
            if (g > 0) begin
                assertions++;
                if (n != 4) begin failures++; $display("[TB] FAIL fair_period_%0d: got %0d cycles expected 4", g, n); end
            end
        end
        req  = '0;
        done = '0;
    endtask

    task automatic test_wrap();
        logic [11:0] s;
        bit ok;
        int n;
        $display("[TB] test_wrap");
        do_reset();
        req  = 12'h400;
        done = 12'hFFF;
        wait_start(s, ok, n);
        assertions++;
        if (!ok || s !== 12'h400) begin failures++; $display("[TB] FAIL wrap_setup: got %h expected 400", s); end
        req = 12'h803;
        wait_start(s, ok, n);
        assertions++;
        if (!ok || s !== 12'h800) begin failures++; $display("[TB] FAIL wrap_first: got %h expected 800", s); end
        wait_start(s, ok, n);
        assertions++;
        if (!ok || s !== 12'h001) begin failures++; $display("[TB] FAIL wrap_second: got %h expected 001", s); end
        wait_start(s, ok, n);
        assertions++;
        if (!ok || s !== 12'h002) begin failures++; $display("[TB] FAIL wrap_third: got %h expected 002", s); end
        req  = '0;
        done = '0;
    endtask

    task automatic test_timeout();
        logic [11:0] s;
        bit ok;
        int n;
        int nwait;
        $display("[TB] test_timeout");
        do_reset();
        req = 12'h004;
        wait_start(s, ok, n);
        assertions++;
        if (!ok || s !== 12'h004) begin failures++; $display("[TB] FAIL tmo_grant: got %h expected 004", s); end
        nwait = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (write_gate !== 1'b1) break;
            nwait++;
        end
        assertions++;
        if (nwait != 16) begin failures++; $display("[TB] FAIL tmo_wait_len: got %0d cycles expected 16", nwait); end
        assertions++;
        if (timeout_err !== 1'b1) begin failures++; $display("[TB] FAIL tmo_pulse: got %b expected 1", timeout_err); end
        tick();
        assertions++;
        if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL tmo_pulse_width: got %b expected 0", timeout_err); end
        wait_start(s, ok, n);
        assertions++;
        if (!ok || s !== 12'h004 || n != 1) begin failures++; $display("[TB] FAIL tmo_next_grant: got %h after %0d edges expected 004 after 1", s, n); end
        for (int i = 1; i <= 16; i++) tick();
        assertions++;
        if (write_gate !== 1'b1) begin failures++; $display("[TB] FAIL tmo_last_wait: got gate %b expected 1", write_gate); end
        done = 12'h004;
        tick();
        done = '0;
        assertions++;
        if (timeout_err !== 1'b0 || write_gate !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tmo_done_priority: got err=%b gate=%b busy=%b expected err=0 gate=0 busy=1", timeout_err, write_gate, busy);
        end
        req = '0;
    endtask

    task automatic test_enable_ignore();
        logic [11:0] s;
        bit ok;
        int n;
        int nbad;
        $display("[TB] test_enable_ignore");
        do_reset();
        req = 12'h080;
        wait_start(s, ok, n);
        assertions++;
        if (!ok || s !== 12'h080) begin failures++; $display("[TB] FAIL en_grant7: got %h expected 080", s); end
        tick();
        done = 12'h008;
        tick();
        tick();
        tick();
        assertions++;
        if (write_gate !== 1'b1 || select !== 4'd7) begin
            failures++;
            $display("[TB] FAIL foreign_done: got gate=%b sel=%0d expected gate=1 sel=7", write_gate, select);
        end
        done   = '0;
        enable = 1'b0;
        req    = 12'hFFF;
        tick();
        assertions++;
        if (write_gate !== 1'b1) begin failures++; $display("[TB] FAIL en_drop_mid_wait: got gate %b expected 1", write_gate); end
        done = 12'h080;
        tick();
        done = '0;
        assertions++;
        if (write_gate !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL en_gap: got gate=%b busy=%b expected 0 1", write_gate, busy); end
        nbad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (start !== 12'h000 || busy !== 1'b0) nbad++;
        end
        assertions++;
        if (nbad != 0) begin failures++; $display("[TB] FAIL en_parked: got %0d active cycles expected 0", nbad); end
        enable = 1'b1;
        wait_start(s, ok, n);
        assertions++;
        if (!ok || s !== 12'h100 || select !== 4'd8) begin
            failures++;
            $display("[TB] FAIL en_resume: got start=%h sel=%0d expected 100 sel=8", s, select);
        end
        req = '0;
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_timeout();
        test_enable_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
